frogger_game_ctrl: RTL and testbench

Game sequencer for the frogger VGA design. It debounces the five active-low push buttons and owns the frog position, lives and score. It generates the lane time base (time_state) that the lane pattern logic consumes. It detects collisions against the lane occupancy bitmaps it receives back and sequences the play/die/win/game-over flow. It sits between the board buttons and both the lane pattern logic and the VGA pixel writer.

---
 rtl/frogger_game_ctrl_if.sv | 34 +++
 rtl/frogger_game_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/frogger_game_ctrl_if.sv
// Button, lane-occupancy and game-status bundle between the frogger sequencer
// and the board/lane/pixel logic around it.
interface frogger_game_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_start;
    logic [7:0] lane1;
    logic [7:0] lane2;
    logic [7:0] lane3;
    logic [7:0] lane5;
    logic [7:0] lane6;
    logic [2:0] time_state;
    logic       lane_tick;
    logic [2:0] frog_row;
    logic [7:0] frog_col;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] game_state;
    logic       hit;

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_start,
        input  lane1, lane2, lane3, lane5, lane6,
        output time_state, lane_tick, frog_row, frog_col, lives, score, game_state, hit
    );

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_start,
        output lane1, lane2, lane3, lane5, lane6,
        input  time_state, lane_tick, frog_row, frog_col, lives, score, game_state, hit
    );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: button debounce, frog position, lives/score, lane
// time base, collision detection and the play/die/win/game-over flow.
//
// state    | meaning
// IDLE     | waiting for start, time base frozen
// PLAY     | frog moves, time base runs, collision and win checked
// DYING    | life lost, hold timer running before respawn or game over
// WIN      | crossing scored, hold timer running before respawn
// GAMEOVER | no lives left, frog held until start
module frogger_game_ctrl #(
    parameter int         TICK_DIV  = 100000000,
    parameter int         DEBOUNCE  = 1000000,
    parameter int         HOLD      = 50000000,
    parameter int         LIVES     = 3,
    parameter logic [7:0] START_COL = 8'b0001_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    frogger_game_ctrl_if.slave   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_DYING = 3'd2;
    localparam logic [2:0] S_WIN   = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_START = 4;

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int HW = $clog2(HOLD + 1);

    localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);
    localparam logic [1:0]    LIVES_LD = 2'(LIVES);

    logic [4:0]    raw;
    logic [4:0]    prev_q;
    logic [4:0]    db_q;
    logic [4:0]    ev_q;
    logic [CW-1:0] cnt_q [5];

    logic [2:0]    state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [7:0]    col_q, col_d;
    logic [1:0]    lives_q, lives_d;
    logic [7:0]    score_q, score_d;
    logic [2:0]    ts_q, ts_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          tick_q, tick_d;
    logic          hit_q, hit_d;
    logic [7:0]    lane_sel;
    logic          coll;

    assign raw = {bus.btn_start, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    // Debounced level only follows raw after DEBOUNCE stable cycles; the
    // counter saturates so a held button cannot re-trigger.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= '1;
            db_q   <= '1;
            ev_q   <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            prev_q <= raw;
            for (int i = 0; i < 5; i++) begin
                if (raw[i] != prev_q[i]) begin
                    cnt_q[i] <= '0;
                    ev_q[i]  <= 1'b0;
                end else if (cnt_q[i] == DB_MAX) begin
                    db_q[i] <= raw[i];
                    ev_q[i] <= db_q[i] & ~raw[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                    ev_q[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        lane_sel = 8'h00;
        case (row_q)
            3'd1:    lane_sel = bus.lane1;
            3'd2:    lane_sel = bus.lane2;
            3'd3:    lane_sel = bus.lane3;
            3'd5:    lane_sel = bus.lane5;
            3'd6:    lane_sel = bus.lane6;
            default: lane_sel = 8'h00;
        endcase
    end

    assign coll = |(lane_sel & col_q);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lives_d = lives_q;
        score_d = score_q;
        ts_d    = ts_q;
        tcnt_d  = tcnt_q;
        hold_d  = hold_q;
        tick_d  = 1'b0;
        hit_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev_q[B_START]) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_LD;
                    score_d = 8'd0;
                    ts_d    = 3'd0;
                    tcnt_d  = TICK_MAX;
                    row_d   = 3'd7;
                    col_d   = START_COL;
                end
            end
            S_PLAY: begin
                if (tcnt_q == '0) begin
                    tcnt_d = TICK_MAX;
                    ts_d   = ts_q + 3'd1;
                    tick_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
                // One move per cycle, up > down > left > right.
                if (ev_q[B_UP]) begin
                    if (row_q != 3'd0) row_d = row_q - 3'd1;
                end else if (ev_q[B_DOWN]) begin
                    if (row_q != 3'd7) row_d = row_q + 3'd1;
                end else if (ev_q[B_LEFT]) begin
                    if (!col_q[7]) col_d = col_q << 1;
                end else if (ev_q[B_RIGHT]) begin
                    if (!col_q[0]) col_d = col_q >> 1;
                end
                if (coll) begin
                    hit_d   = 1'b1;
                    state_d = S_DYING;
                    lives_d = lives_q - 2'd1;
                    hold_d  = HOLD_MAX;
                end else if (row_q == 3'd0) begin
                    state_d = S_WIN;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    hold_d  = HOLD_MAX;
                end
            end
            S_DYING: begin
                if (hold_q == '0) begin
                    if (lives_q == 2'd0) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_PLAY;
                        row_d   = 3'd7;
                        col_d   = START_COL;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_WIN: begin
                if (hold_q == '0) begin
                    state_d = S_PLAY;
                    row_d   = 3'd7;
                    col_d   = START_COL;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_OVER: begin
                if (ev_q[B_START]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= 3'd7;
            col_q   <= START_COL;
            lives_q <= LIVES_LD;
            score_q <= 8'd0;
            ts_q    <= 3'd0;
            tcnt_q  <= TICK_MAX;
            hold_q  <= '0;
            tick_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lives_q <= lives_d;
            score_q <= score_d;
            ts_q    <= ts_d;
            tcnt_q  <= tcnt_d;
            hold_q  <= hold_d;
            tick_q  <= tick_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.time_state = ts_q;
    assign bus.lane_tick  = tick_q;
    assign bus.frog_row   = row_q;
    assign bus.frog_col   = col_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.game_state = state_q;
    assign bus.hit        = hit_q;
endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed bench for frogger_game_ctrl with short debounce/tick/hold settings.
module tb_frogger_game_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    localparam logic [4:0] M_UP = 5'b00001, M_DOWN = 5'b00010, M_LEFT = 5'b00100,
                           M_RIGHT = 5'b01000, M_START = 5'b10000;

    frogger_game_ctrl_if bus ();

    frogger_game_ctrl #(
        .TICK_DIV(4), .DEBOUNCE(2), .HOLD(3), .LIVES(2), .START_COL(8'b0001_0000)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [4:0] m);
        bus.btn_up    = ~m[0];
        bus.btn_down  = ~m[1];
        bus.btn_left  = ~m[2];
        bus.btn_right = ~m[3];
        bus.btn_start = ~m[4];
    endtask

    task automatic press(input logic [4:0] m);
        set_btn(m);
        repeat (5) tick();
        set_btn(5'b0);
        repeat (5) tick();
    endtask

    task automatic test_reset();
        bus.lane1 = 0; bus.lane2 = 0; bus.lane3 = 0; bus.lane5 = 0; bus.lane6 = 0;
        set_btn(5'b0);
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total++; if (bus.game_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.game_state); end
        total++; if (bus.frog_row !== 3'd7) begin bad++; $display("FAIL reset_row got=%0d want=7", bus.frog_row); end
        total++; if (bus.frog_col !== 8'h10) begin bad++; $display("FAIL reset_col got=%0h want=10", bus.frog_col); end
        total++; if (bus.lives !== 2'd2) begin bad++; $display("FAIL reset_lives got=%0d want=2", bus.lives); end
        total++; if (bus.score !== 8'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", bus.score); end
        total++; if (bus.hit !== 1'b0 || bus.lane_tick !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", bus.hit, bus.lane_tick); end
        begin
            int ticks = 0;
            repeat (20) begin tick(); if (bus.lane_tick) ticks++; end
            total++; if (bus.time_state !== 3'd0 || ticks != 0) begin bad++; $display("FAIL idle_frozen ts=%0d ticks=%0d want 0/0", bus.time_state, ticks); end
        end
    endtask

    task automatic test_start();
        int n = 0;
        set_btn(M_START);
        while (n < 5 && bus.game_state !== 3'd1) begin tick(); n++; end
        total++; if (bus.game_state !== 3'd1) begin bad++; $display("FAIL start_play got=%0d want=1 after %0d cycles", bus.game_state, n); end
        total++; if (n != 5) begin bad++; $display("FAIL start_latency got=%0d want=5", n); end
        repeat (5) tick();
        set_btn(5'b0);
        repeat (5) tick();
        total++; if (bus.frog_row !== 3'd7 || bus.frog_col !== 8'h10) begin bad++; $display("FAIL start_pos got=%0d/%0h want=7/10", bus.frog_row, bus.frog_col); end
        total++; if (bus.lives !== 2'd2 || bus.score !== 8'd0) begin bad++; $display("FAIL start_lives_score got=%0d/%0d want=2/0", bus.lives, bus.score); end
    endtask

    task automatic test_bounds();
        press(M_DOWN);
        total++; if (bus.frog_row !== 3'd7) begin bad++; $display("FAIL down_at_7 got=%0d want=7", bus.frog_row); end
        repeat (3) press(M_LEFT);
        total++; if (bus.frog_col !== 8'h80) begin bad++; $display("FAIL left_3 got=%0h want=80", bus.frog_col); end
        press(M_LEFT);
        total++; if (bus.frog_col !== 8'h80) begin bad++; $display("FAIL left_edge got=%0h want=80", bus.frog_col); end
        repeat (7) press(M_RIGHT);
        total++; if (bus.frog_col !== 8'h01) begin bad++; $display("FAIL right_7 got=%0h want=01", bus.frog_col); end
        press(M_RIGHT);
        total++; if (bus.frog_col !== 8'h01) begin bad++; $display("FAIL right_edge got=%0h want=01", bus.frog_col); end
        repeat (4) press(M_LEFT);
        total++; if (bus.frog_col !== 8'h10) begin bad++; $display("FAIL back_center got=%0h want=10", bus.frog_col); end
    endtask

    task automatic test_hold_priority();
        set_btn(M_UP);
        repeat (50) tick();
        set_btn(5'b0);
        repeat (6) tick();
        total++; if (bus.frog_row !== 3'd6) begin bad++; $display("FAIL hold_once got=%0d want=6", bus.frog_row); end
        press(M_UP | M_LEFT);
        total++; if (bus.frog_row !== 3'd5 || bus.frog_col !== 8'h10) begin bad++; $display("FAIL up_beats_left got=%0d/%0h want=5/10", bus.frog_row, bus.frog_col); end
        press(M_DOWN | M_RIGHT);
        total++; if (bus.frog_row !== 3'd6 || bus.frog_col !== 8'h10) begin bad++; $display("FAIL down_beats_right got=%0d/%0h want=6/10", bus.frog_row, bus.frog_col); end
    endtask

    task automatic test_timebase();
        int n = 0;
        logic [2:0] ts0, exp_ts;
        while (n < 8 && !bus.lane_tick) begin tick(); n++; end
        total++; if (!bus.lane_tick) begin bad++; $display("FAIL tick_seen got=0 want=1"); end
        ts0 = bus.time_state;
        for (int k = 1; k <= 9; k++) begin
            n = 0;
            do begin tick(); n++; end while (!bus.lane_tick && n < 8);
            exp_ts = ts0 + 3'(k);
            total++; if (n != 4 || bus.time_state !== exp_ts) begin bad++; $display("FAIL tick_step%0d period=%0d ts=%0d want 4/%0d", k, n, bus.time_state, exp_ts); end
        end
    endtask

    task automatic test_collision();
        bus.lane6 = 8'h10;
        tick();
        total++; if (bus.hit !== 1'b1 || bus.game_state !== 3'd2 || bus.lives !== 2'd1) begin bad++; $display("FAIL hit1 got hit=%b st=%0d lives=%0d want 1/2/1", bus.hit, bus.game_state, bus.lives); end
        bus.lane6 = 8'h00;
        tick();
        total++; if (bus.hit !== 1'b0 || bus.game_state !== 3'd2) begin bad++; $display("FAIL hit1_pulse got hit=%b st=%0d want 0/2", bus.hit, bus.game_state); end
        tick();
        tick();
        total++; if (bus.game_state !== 3'd1 || bus.frog_row !== 3'd7 || bus.frog_col !== 8'h10) begin bad++; $display("FAIL respawn got st=%0d pos=%0d/%0h want 1/7/10", bus.game_state, bus.frog_row, bus.frog_col); end
        press(M_UP);
        bus.lane6 = 8'h10;
        tick();
        total++; if (bus.hit !== 1'b1 || bus.lives !== 2'd0) begin bad++; $display("FAIL hit2 got hit=%b lives=%0d want 1/0", bus.hit, bus.lives); end
        bus.lane6 = 8'h00;
        repeat (3) tick();
        total++; if (bus.game_state !== 3'd4 || bus.frog_row !== 3'd6) begin bad++; $display("FAIL gameover got st=%0d row=%0d want 4/6", bus.game_state, bus.frog_row); end
        press(M_UP);
        total++; if (bus.frog_row !== 3'd6) begin bad++; $display("FAIL over_no_move got=%0d want=6", bus.frog_row); end
    endtask

    task automatic test_restart();
        logic [2:0] ts0;
        press(M_START);
        total++; if (bus.game_state !== 3'd0) begin bad++; $display("FAIL over_to_idle got=%0d want=0", bus.game_state); end
        ts0 = bus.time_state;
        repeat (20) tick();
        total++; if (bus.time_state !== ts0) begin bad++; $display("FAIL idle_ts_frozen got=%0d want=%0d", bus.time_state, ts0); end
        press(M_START);
        total++; if (bus.game_state !== 3'd1 || bus.lives !== 2'd2 || bus.score !== 8'd0 || bus.frog_row !== 3'd7) begin bad++; $display("FAIL restart got st=%0d lives=%0d score=%0d row=%0d want 1/2/0/7", bus.game_state, bus.lives, bus.score, bus.frog_row); end
    endtask

    task automatic do_win(input logic [7:0] exp_score, input bit verbose);
        int n = 0;
        repeat (6) press(M_UP);
        set_btn(M_UP);
        while (n < 8 && bus.game_state !== 3'd3) begin tick(); n++; end
        total++; if (bus.game_state !== 3'd3 || bus.score !== exp_score) begin bad++; $display("FAIL win got st=%0d score=%0d want 3/%0d", bus.game_state, bus.score, exp_score); end
        set_btn(5'b0);
        repeat (6) tick();
        if (verbose) begin
            total++; if (bus.game_state !== 3'd1 || bus.frog_row !== 3'd7 || bus.frog_col !== 8'h10) begin bad++; $display("FAIL win_respawn got st=%0d pos=%0d/%0h want 1/7/10", bus.game_state, bus.frog_row, bus.frog_col); end
        end
    endtask

    task automatic test_win();
        do_win(8'd1, 1'b1);
    endtask

    task automatic test_score_saturate();
        for (int s = 2; s <= 255; s++) do_win(8'(s), 1'b0);
        do_win(8'd255, 1'b1);
    endtask

    task automatic test_reset_mid_dying();
        press(M_UP);
        bus.lane6 = 8'h10;
        tick();
        total++; if (bus.game_state !== 3'd2 || bus.hit !== 1'b1) begin bad++; $display("FAIL pre_reset got st=%0d hit=%b want 2/1", bus.game_state, bus.hit); end
        bus.lane6 = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.game_state !== 3'd0 || bus.frog_row !== 3'd7 || bus.frog_col !== 8'h10) begin bad++; $display("FAIL async_reset_pos got st=%0d pos=%0d/%0h want 0/7/10", bus.game_state, bus.frog_row, bus.frog_col); end
        total++; if (bus.lives !== 2'd2 || bus.score !== 8'd0 || bus.time_state !== 3'd0) begin bad++; $display("FAIL async_reset_vals got lives=%0d score=%0d ts=%0d want 2/0/0", bus.lives, bus.score, bus.time_state); end
        total++; if (bus.hit !== 1'b0 || bus.lane_tick !== 1'b0) begin bad++; $display("FAIL async_reset_pulses got=%b%b want=00", bus.hit, bus.lane_tick); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounds();
        test_hold_priority();
        test_timebase();
        test_collision();
        test_restart();
        test_win();
        test_score_saturate();
        test_reset_mid_dying();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
